// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer (one-shot / auto-reload) with a level interrupt.
// Optional macro TIMER_STATUS_EN exposes irq_flag (bit4) and FSM state (bits[6:5]) on CTRL reads.
module timer_dev #(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        flag_set_s;
  logic        flag_clr_s;
  logic        en_clr_s;
  logic        ctrl_wr_s;
  logic        preset_wr_s;
  logic        auto_s;
  logic [31:0] ctrl_rd_s;
  logic        unused_addr_s;

  assign ctrl_wr_s     = WE & (Addr[3:2] == OFF_CTRL);
  assign preset_wr_s   = WE & (Addr[3:2] == OFF_PRESET);
  assign auto_s        = (mode_q == 2'b01);
  assign unused_addr_s = ^{Addr[31:4], Addr[1:0]};

  // Countdown FSM: next state, next count and flag/enable side effects
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    flag_set_s = 1'b0;
    flag_clr_s = 1'b0;
    en_clr_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 1 or 0 both expire here, so COUNT never wraps
          count_d    = 32'd0;
          flag_set_s = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (auto_s) begin
          flag_clr_s = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          en_clr_s = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register-file next state: a CTRL write overrides every FSM side effect on the same edge
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    flag_d   = flag_q;
    preset_d = preset_q;
    if (ctrl_wr_s) begin
      en_d   = WD[0];
      mode_d = WD[2:1];
      im_d   = WD[3];
      flag_d = 1'b0;
    end else begin
      en_d   = en_q & ~en_clr_s;
      flag_d = (flag_q | flag_set_s) & ~flag_clr_s;
    end
    if (preset_wr_s) begin
      preset_d = WD;
    end else begin
      preset_d = preset_q;
    end
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // CTRL read view, optionally with raw flag and state
  always_comb begin
    ctrl_rd_s      = 32'd0;
    ctrl_rd_s[3:0] = {im_q, mode_q, en_q};
`ifdef TIMER_STATUS_EN
    ctrl_rd_s[4]   = flag_q;
    ctrl_rd_s[6:5] = state_q;
`endif
  end

  // Combinational read mux on Addr[3:2]
  always_comb begin
    RD = 32'd0;
    case (Addr[3:2])
      OFF_CTRL:   RD = ctrl_rd_s;
      OFF_PRESET: RD = preset_q;
      OFF_COUNT:  RD = count_q;
      default:    RD = 32'd0;
    endcase
  end

  assign IRQ = im_q & flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: vector table, directed multi-cycle sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_timer_dev;

  localparam logic [31:0] RP   = 32'h1234_0007;
  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TIMER_STATUS_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`else
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_FFFF;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_EXP  = 3;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model of the timer as seen from the bus
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  typedef struct {
    logic        we;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [0:8];

  timer_dev #(.RESET_PRESET(RP)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .WD   (WD),
    .RD   (RD),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic model_step(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic [1:0] off;
    off = a[3:2];
    if (r) begin
      m_en = 1'b0; m_mode = 2'b00; m_im = 1'b0; m_preset = RP;
      m_count = 32'd0; m_flag = 1'b0; m_phase = PH_IDLE;
    end else begin
      if (m_phase == PH_IDLE) begin
        if (m_en) m_phase = PH_LOAD;
      end else if (m_phase == PH_LOAD) begin
        m_count = m_preset;
        m_phase = PH_RUN;
      end else if (m_phase == PH_RUN) begin
        if (!m_en) m_phase = PH_IDLE;
        else if (m_count <= 32'd1) begin
          m_count = 32'd0; m_flag = 1'b1; m_phase = PH_EXP;
        end else m_count = m_count - 32'd1;
      end else begin
        if (m_mode == 2'b01) begin
          m_flag = 1'b0; m_phase = PH_LOAD;
        end else begin
          m_en = 1'b0; m_phase = PH_IDLE;
        end
      end
      if (we && off == 2'd0) begin
        m_en = wd[0]; m_mode = wd[2:1]; m_im = wd[3]; m_flag = 1'b0;
      end
      if (we && off == 2'd1) m_preset = wd;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] v;
    logic [1:0]  off;
    off = a[3:2];
    v = 32'd0;
    if (off == 2'd0) begin
      v[0] = m_en; v[2:1] = m_mode; v[3] = m_im;
`ifdef TIMER_STATUS_EN
      v[4] = m_flag;
      v[6:5] = m_phase[1:0];
`endif
    end else if (off == 2'd1) v = m_preset;
    else if (off == 2'd2) v = m_count;
    return v;
  endfunction

  // one clock edge with the given bus inputs; DUT compared with the model afterwards
  task automatic step(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
    reset = r; WE = we; Addr = a; WD = wd;
    @(posedge clk);
    model_step(r, we, a, wd);
    #1;
    check("model_rd", RD, model_rd(a));
    check("model_irq", {31'd0, IRQ}, {31'd0, m_im & m_flag});
  endtask

  task automatic rd(input logic [3:0] off);
    step(1'b0, 1'b0, BASE + {28'd0, off}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] val);
    step(1'b0, 1'b1, BASE + {28'd0, off}, val);
  endtask

  task automatic rst();
    step(1'b1, 1'b0, BASE, 32'd0);
    step(1'b1, 1'b0, BASE, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_cnt [0:4];
    logic        r;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    int          pulses;
    int          p;

    reset = 1'b1; WE = 1'b0; Addr = BASE; WD = 32'd0;

    vecs[0] = '{1'b0, 4'h0, 32'd0,          32'd0,       1'b0};
    vecs[1] = '{1'b0, 4'h4, 32'd0,          RP,          1'b0};
    vecs[2] = '{1'b0, 4'h8, 32'd0,          32'd0,       1'b0};
    vecs[3] = '{1'b0, 4'hC, 32'd0,          32'd0,       1'b0};
    vecs[4] = '{1'b1, 4'hC, 32'hFFFF_FFFF,  32'd0,       1'b0};
    vecs[5] = '{1'b1, 4'h8, 32'h0000_0055,  32'd0,       1'b0};
    vecs[6] = '{1'b1, 4'h4, 32'd5,          32'd5,       1'b0};
    vecs[7] = '{1'b1, 4'h0, 32'hFFFF_FFF6,  32'h6,       1'b0};
    vecs[8] = '{1'b1, 4'h0, 32'd0,          32'd0,       1'b0};

    // reset values
    step(1'b1, 1'b0, BASE, 32'd0);
    step(1'b1, 1'b0, BASE + 32'h0, 32'd0);
    check("rst_ctrl", RD, 32'd0);
    check_irq("rst_irq", 1'b0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    check("rst_count", RD, 32'd0);
    step(1'b1, 1'b0, BASE + 32'hC, 32'd0);
    check("rst_offc", RD, 32'd0);
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    check("rst_preset", RD, RP);

    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].we, BASE + {28'd0, vecs[i].off}, vecs[i].wd);
      check("vec_rd", RD, vecs[i].exp_rd);
      check_irq("vec_irq", vecs[i].exp_irq);
    end

    // one-shot, PRESET=5
    rst();
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      rd(4'h8);
      check("os_count", RD, (k == 1) ? 32'd0 : 32'(7 - k));
      check_irq("os_irq", k == 7);
    end
    rd(4'h0);
    check("os_ctrl1", RD & CTRL_MASK, 32'h8);
    rd(4'h0);
    check("os_ctrl2", RD & CTRL_MASK, 32'h8);
    for (int k = 0; k < 20; k++) begin
      rd(4'h8);
      check_irq("os_hold", 1'b1);
    end
    wr(4'h0, 32'h8);
    check_irq("os_clear", 1'b0);

    // auto-reload, PRESET=3
    rst();
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    exp_cnt[0] = 32'd3; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1;
    exp_cnt[3] = 32'd0; exp_cnt[4] = 32'd0;
    pulses = 0;
    for (int k = 1; k <= 21; k++) begin
      rd(4'h8);
      if (IRQ) pulses++;
      if (k == 1) begin
        check("ar_count1", RD, 32'd0);
        check_irq("ar_irq1", 1'b0);
      end else begin
        p = (k - 2) % 5;
        check("ar_count", RD, exp_cnt[p]);
        check_irq("ar_irq", p == 3);
      end
    end
    check("ar_pulses", 32'(pulses), 32'd4);

    // PRESET=0 expires 3 edges after enabling
    rst();
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      rd(4'h8);
      check_irq("p0_irq", k == 3);
    end

    // masked interrupt never reaches IRQ
    rst();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1);
    exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1;
    exp_cnt[3] = 32'd0; exp_cnt[4] = 32'd0;
    for (int k = 0; k < 5; k++) begin
      rd(4'h8);
      check("mask_count", RD, exp_cnt[k]);
      check_irq("mask_irq", 1'b0);
    end

    // disable mid-count, COUNT holds at 1; COUNT write ignored
    rst();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1);
    rd(4'h8);
    rd(4'h8);
    check("dis_count2", RD, 32'd2);
    wr(4'h0, 32'h0);
    check("dis_ctrl", RD & CTRL_MASK, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd(4'h8);
      check("dis_hold", RD, 32'd1);
      check_irq("dis_irq", 1'b0);
    end
    wr(4'h8, 32'hFF);
    check("cnt_wr_ignored", RD, 32'd1);

    // PRESET write during CNT affects only the next load
    rst();
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    rd(4'h8);
    rd(4'h8);
    check("pw_count3", RD, 32'd3);
    wr(4'h4, 32'd9);
    check("pw_preset", RD, 32'd9);
    rd(4'h8);
    check("pw_count1", RD, 32'd1);
    rd(4'h8);
    check("pw_count0", RD, 32'd0);
    check_irq("pw_irq", 1'b1);
    rd(4'h8);
    check_irq("pw_irq_drop", 1'b0);
    rd(4'h8);
    check("pw_reload9", RD, 32'd9);
    rd(4'h8);
    check("pw_count8", RD, 32'd8);

    // CTRL write colliding with expiry: write wins
    rst();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h9);
    rd(4'h8);
    rd(4'h8);
    rd(4'h8);
    check("col_count1", RD, 32'd1);
    wr(4'h0, 32'h8);
    check("col_ctrl", RD & CTRL_MASK, 32'h8);
    check_irq("col_irq", 1'b0);
    rd(4'h8);
    check("col_count0", RD, 32'd0);
    check_irq("col_irq2", 1'b0);
    rd(4'h0);
    check("col_ctrl2", RD & CTRL_MASK, 32'h8);

    // randomized traffic against the model
    rst();
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      we = ($urandom_range(0, 5) == 0);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = BASE + ($urandom_range(0, 3) << 2);
      wd = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15);
      step(r, we, a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
